reflet_int_to_float_serial: RTL and testbench
=============================================

REFLET_INT_TO_FLOAT_SERIAL -- requirements
Module: reflet_int_to_float_serial

Interface
REQ-001 SHALL have parameter int_size, default 16: width of the two's-complement signed integer input.
REQ-002 SHALL have parameter float_size, default 32: width of the IEEE-754-style float output (16/32/64).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port int_in, input, int_size: signed integer operand.
REQ-006 SHALL have port in_valid, input, 1: int_in valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-008 SHALL have port float_out, output, float_size: converted float.
REQ-009 SHALL have port out_valid, output, 1: float_out valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts float_out.

Function
REQ-011 SHALL use states IDLE, NORM, DONE; in_ready=1 only in IDLE.
REQ-012 SHALL, in IDLE on in_valid=1, latch sign=int_in[msb] and abs=|int_in| as int_size-bit unsigned (most negative value gives 2^(int_size-1)), clear shift count, and go to NORM.
REQ-013 SHALL, in NORM with abs=0, load float_out=0 (+0.0), set out_valid, and go to DONE.
REQ-014 SHALL, in NORM with abs MSB=0, shift abs left by one and increment shift count each cycle.
REQ-015 SHALL, in NORM with abs MSB=1, pack sign, exponent=bias+int_size-1-shift_count, and mantissa=the bits below the MSB, left-aligned into the mantissa field; zero-pad if fewer bits, otherwise truncate toward zero; set out_valid; go to DONE.
REQ-016 SHALL assert out_valid exactly lz+2 cycles after the acceptance edge, where lz is the leading-zero count of abs (zero input: 2 cycles).
REQ-017 SHALL hold float_out and out_valid stable in DONE while out_ready=0.
REQ-018 SHALL, in DONE with out_ready=1, deassert out_valid on the next edge and return to IDLE; a new operand is accepted no earlier than the following cycle.
REQ-019 SHALL size shift count at clog2(int_size)+1 bits; the exponent SHALL never overflow because int_size-1 < 2^(exponent_size-1).

Reset
REQ-020 SHALL, on reset=1 at a clock edge in any state (including mid-NORM), go to IDLE, discard the operand, and drive out_valid=0, float_out=0, in_ready=1 from the next cycle.

Configuration
REQ-021 SHALL, with macro REFLET_FLOAT_ROUND_EN defined, round the truncated mantissa to nearest, ties to even, using guard and sticky bits; a mantissa carry-out SHALL increment the exponent and clear the mantissa.
REQ-022 SHALL, without REFLET_FLOAT_ROUND_EN, truncate toward zero; latency SHALL be identical in both builds.

Structure
REQ-023 SHALL take exponent_size, mantissa_size and exponent_bias from the shared reflet_float.vh function set; the state encoding constants SHALL also live there.
REQ-024 SHALL be a single module; the rounding logic is the only natural sub-module candidate, named reflet_float_round_ne, and it is instantiated only when REFLET_FLOAT_ROUND_EN is defined.

Verification
REQ-025 SHALL cover (16/32): int_in=0x0001 -> float_out=0x3F800000, out_valid 17 cycles after acceptance.
REQ-026 SHALL cover (16/32): int_in=0xFFFE (-2) -> 0xC0000000; int_in=0x8000 -> 0xC7000000, 2 cycles.
REQ-027 SHALL cover (16/32): int_in=0 -> 0x00000000 after 2 cycles; out_ready held 0 for 5 cycles -> output stable and in_ready=0.
REQ-028 SHALL cover (32/32): int_in=0x01000003 -> 0x4B800001 without REFLET_FLOAT_ROUND_EN, 0x4B800002 with it.
REQ-029 SHALL cover reset asserted 3 cycles into NORM with int_in=0x0001 -> IDLE next cycle, out_valid never rises; the next operand 0x0004 -> 0x40800000.

Source files
------------

// File: rtl/reflet_int_to_float_serial_pkg.sv
// Shared float-format helpers and FSM state encoding for the serial int-to-float converter.
package reflet_int_to_float_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exponent field width for a 16/32/64-bit IEEE-754 format.
  function automatic int unsigned exponent_size(input int unsigned float_size);
    case (float_size)
      16:      exponent_size = 5;
      64:      exponent_size = 11;
      default: exponent_size = 8;
    endcase
  endfunction

  // Mantissa (fraction) field width, hidden bit excluded.
  function automatic int unsigned mantissa_size(input int unsigned float_size);
    mantissa_size = float_size - exponent_size(float_size) - 1;
  endfunction

  // Exponent bias: 2^(exponent_size-1) - 1.
  function automatic int unsigned exponent_bias(input int unsigned float_size);
    exponent_bias = (32'd1 << (exponent_size(float_size) - 1)) - 1;
  endfunction

endpackage

// File: rtl/reflet_float_round_ne.sv
// Round-to-nearest-even on a truncated mantissa; carry-out bumps the exponent.
module reflet_float_round_ne #(
  parameter int unsigned exp_w = 8,
  parameter int unsigned man_w = 23
) (
  input  logic [exp_w-1:0] exp_in,
  input  logic [man_w-1:0] mant_in,
  input  logic             guard,
  input  logic             sticky,
  output logic [exp_w-1:0] exp_c,
  output logic [man_w-1:0] mant_c
);

  logic             round_up;
  logic             carry;
  logic [man_w-1:0] mant_sum;

  // Increment when above half, or exactly half with an odd LSB; a wrap clears the mantissa.
  always_comb begin
    round_up          = guard & (sticky | mant_in[0]);
    {carry, mant_sum} = {1'b0, mant_in} + (man_w + 1)'(round_up);
    mant_c            = mant_sum;
    exp_c             = exp_in + exp_w'(carry);
  end

endmodule

// File: rtl/reflet_int_to_float_serial.sv
// Serial signed-integer to IEEE-754 float converter: normalises one bit per cycle.
// Optional macro REFLET_FLOAT_ROUND_EN: round-to-nearest-even instead of truncation.
module reflet_int_to_float_serial
  import reflet_int_to_float_serial_pkg::*;
#(
  parameter int unsigned int_size   = 16,
  parameter int unsigned float_size = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [int_size-1:0]   int_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [float_size-1:0] float_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned exp_w  = exponent_size(float_size);
  localparam int unsigned man_w  = mantissa_size(float_size);
  localparam int unsigned bias   = exponent_bias(float_size);
  localparam int unsigned cnt_w  = $clog2(int_size) + 1;
  localparam int unsigned frac_w = int_size - 1;

  state_t              state;
  logic                sign;
  logic [int_size-1:0] mag;
  logic [cnt_w-1:0]    shift_cnt;
  logic [int_size-1:0] abs_in;
  logic [exp_w-1:0]    exp_raw;
  logic [man_w-1:0]    mant_raw;
  logic [exp_w-1:0]    exp_fin;
  logic [man_w-1:0]    mant_fin;

  // Magnitude of the operand; the most negative value wraps to 2^(int_size-1) as intended.
  assign abs_in  = int_in[int_size-1] ? (~int_in + int_size'(1)) : int_in;

  // Exponent from the position of the leading one.
  assign exp_raw = exp_w'(bias + int_size - 1) - exp_w'(shift_cnt);

`ifdef REFLET_FLOAT_ROUND_EN
  localparam int unsigned ext_w = frac_w + man_w + 2;

  logic [ext_w-1:0] ext;
  logic             guard;
  logic             sticky;

  // Fraction left-aligned with two extra positions for guard and sticky.
  assign ext      = {mag[int_size-2:0], {(man_w + 2){1'b0}}};
  assign mant_raw = ext[ext_w-1 -: man_w];
  assign guard    = ext[ext_w-1-man_w];
  assign sticky   = |ext[ext_w-man_w-2:0];

  reflet_float_round_ne #(
    .exp_w (exp_w),
    .man_w (man_w)
  ) u_round (
    .exp_in  (exp_raw),
    .mant_in (mant_raw),
    .guard   (guard),
    .sticky  (sticky),
    .exp_c   (exp_fin),
    .mant_c  (mant_fin)
  );
`else
  // Fraction left-aligned in the mantissa field: zero-padded or truncated toward zero.
  assign mant_raw = man_w'({mag[int_size-2:0], {man_w{1'b0}}} >> frac_w);
  assign exp_fin  = exp_raw;
  assign mant_fin = mant_raw;
`endif

  // Control FSM with registered handshake and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      float_out <= '0;
      sign      <= 1'b0;
      mag       <= '0;
      shift_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign      <= int_in[int_size-1];
            mag       <= abs_in;
            shift_cnt <= '0;
            in_ready  <= 1'b0;
            state     <= NORM;
          end
        end
        NORM: begin
          if (mag == '0) begin
            float_out <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!mag[int_size-1]) begin
            mag       <= mag << 1;
            shift_cnt <= shift_cnt + cnt_w'(1);
          end else begin
            float_out <= {sign, exp_fin, mant_fin};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_int_to_float_serial.sv
// Bench for reflet_int_to_float_serial: a 16/32 and a 32/32 instance, scoreboard-checked.
module tb_reflet_int_to_float_serial;

  typedef struct {
    logic [31:0] f;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] val;
    int          sel;
    logic [31:0] ef;
    int          el;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] int_in;
  logic        in_valid;
  logic        out_ready;
  int          sel;

  logic        a_in_valid, a_out_ready, a_in_ready, a_out_valid;
  logic [31:0] a_float_out;
  logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [31:0] b_float_out;

  logic        cur_in_ready, cur_out_valid;
  logic [31:0] cur_float;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  assign a_in_valid    = in_valid && (sel == 0);
  assign b_in_valid    = in_valid && (sel == 1);
  assign a_out_ready   = out_ready && (sel == 0);
  assign b_out_ready   = out_ready && (sel == 1);
  assign cur_in_ready  = (sel == 0) ? a_in_ready  : b_in_ready;
  assign cur_out_valid = (sel == 0) ? a_out_valid : b_out_valid;
  assign cur_float     = (sel == 0) ? a_float_out : b_float_out;

  reflet_int_to_float_serial #(.int_size(16), .float_size(32)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .int_in    (int_in[15:0]),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .float_out (a_float_out),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  reflet_int_to_float_serial #(.int_size(32), .float_size(32)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .int_in    (int_in),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .float_out (b_float_out),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference for 16-bit ints: every such value is exact in single precision.
  function automatic void model16(input logic [15:0] v, output logic [31:0] f, output int lat);
    logic [15:0] a;
    logic [31:0] sh;
    int p;
    a = v[15] ? (~v + 16'd1) : v;
    if (a == 16'd0) begin
      f   = 32'd0;
      lat = 2;
    end else begin
      p = 15;
      while (!a[p]) p--;
      sh  = 32'(a) << (23 - p);
      f   = {v[15], 8'(127 + p), sh[22:0]};
      lat = (15 - p) + 2;
    end
  endfunction

  task automatic run_op(input logic [31:0] val, input int s, input logic [31:0] ef,
                        input int el, input int hold, input string nm);
    int   w;
    int   lat;
    exp_t e;
    sel = s;
    w   = 0;
    @(negedge clk);
    while (!cur_in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " in_ready_before"}, 64'(cur_in_ready), 64'd1);
    int_in   = val;
    in_valid = 1'b1;
    sb.push_back('{f: ef, lat: el});
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!cur_out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({nm, " out_valid"}, 64'(cur_out_valid), 64'd1);
    chk({nm, " latency"}, 64'(lat), 64'(e.lat));
    chk({nm, " float_out"}, 64'(cur_float), 64'(e.f));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold_valid"}, 64'(cur_out_valid), 64'd1);
      chk({nm, " hold_float"}, 64'(cur_float), 64'(e.f));
      chk({nm, " hold_in_ready"}, 64'(cur_in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " valid_drop"}, 64'(cur_out_valid), 64'd0);
    chk({nm, " ready_back"}, 64'(cur_in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rf;
    logic [15:0] rv;
    int          rl;
    int          rose;

    // Directed vectors: {value, instance, expected float, expected latency, hold cycles}.
    tbl[0] = '{32'h0000_0001, 0, 32'h3F80_0000, 17, 0};
    tbl[1] = '{32'h0000_FFFE, 0, 32'hC000_0000, 16, 0};
    tbl[2] = '{32'h0000_8000, 0, 32'hC700_0000,  2, 0};
    tbl[3] = '{32'h0000_0000, 0, 32'h0000_0000,  2, 5};
    tbl[4] = '{32'h0000_7FFF, 0, 32'h46FF_FE00,  3, 2};
    tbl[5] = '{32'h0000_FFFF, 0, 32'hBF80_0000, 17, 0};
`ifdef REFLET_FLOAT_ROUND_EN
    tbl[6] = '{32'h0100_0003, 1, 32'h4B80_0002,  9, 0};
    tbl[7] = '{32'h7FFF_FFFF, 1, 32'h4F00_0000,  3, 0};
`else
    tbl[6] = '{32'h0100_0003, 1, 32'h4B80_0001,  9, 0};
    tbl[7] = '{32'h7FFF_FFFF, 1, 32'h4EFF_FFFF,  3, 0};
`endif
    tbl[8] = '{32'h0100_0001, 1, 32'h4B80_0000,  9, 0};
    tbl[9] = '{32'h8000_0000, 1, 32'hCF00_0000,  2, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    int_in    = 32'd0;
    sel       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset a in_ready", 64'(a_in_ready), 64'd1);
    chk("reset a out_valid", 64'(a_out_valid), 64'd0);
    chk("reset a float_out", 64'(a_float_out), 64'd0);
    chk("reset b in_ready", 64'(b_in_ready), 64'd1);
    chk("reset b out_valid", 64'(b_out_valid), 64'd0);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].val, tbl[i].sel, tbl[i].ef, tbl[i].el, tbl[i].hold, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom);
      model16(rv, rf, rl);
      run_op({16'd0, rv}, 0, rf, rl, int'($urandom_range(0, 2)), $sformatf("rnd%0d_%h", i, rv));
    end

    // Reset three cycles into normalisation must abort the operand.
    sel = 0;
    @(negedge clk);
    int_in   = 32'h0000_0001;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midnorm reset in_ready", 64'(a_in_ready), 64'd1);
    chk("midnorm reset out_valid", 64'(a_out_valid), 64'd0);
    chk("midnorm reset float_out", 64'(a_float_out), 64'd0);
    rose = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_out_valid) rose = 1;
    end
    chk("midnorm no out_valid", 64'(rose), 64'd0);
    run_op(32'h0000_0004, 0, 32'h4080_0000, 15, 0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
